// File: rtl/parking_lot_occupancy.sv
// Parking lot occupancy counter with BCD tracking
// and a multiplexed active-low 7-segment display.
module parking_lot_occupancy #(
  parameter int CAPACITY     = 99,
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr_err,
  output logic [6:0] count,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       full,
  output logic       empty,
  output logic       ovf_err,
  output logic       unf_err,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam logic [6:0] CAP = 7'(CAPACITY);

  logic                    armed;
  logic                    up;
  logic                    dn;
  logic                    ovf_ev;
  logic                    unf_ev;
  logic [3:0]              tens_nx;
  logic [3:0]              ones_nx;
  logic [3:0]              digit;
  logic                    msb;
  logic [REFRESH_BITS-1:0] refresh;

  assign full  = (count == CAP);
  assign empty = (count == 7'd0);

  assign up     = armed & inc & ~dec & ~full;
  assign dn     = armed & dec & ~inc & ~empty;
  assign ovf_ev = armed & inc & ~dec & full;
  assign unf_ev = armed & dec & ~inc & empty;

  // armed stays low through the first edge after reset
  // release so pulses coinciding with release are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // binary occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  count <= 7'd0;
    else if (up) count <= count + 7'd1;
    else if (dn) count <= count - 7'd1;
  end

  // BCD digits stepped in lockstep with count
  always_comb begin
    tens_nx = bcd_tens;
    ones_nx = bcd_ones;
    unique case (1'b1)
      up: begin
        if (bcd_ones == 4'd9) begin
          ones_nx = 4'd0;
          tens_nx = bcd_tens + 4'd1;
        end else begin
          ones_nx = bcd_ones + 4'd1;
        end
      end
      dn: begin
        if (bcd_ones == 4'd0) begin
          ones_nx = 4'd9;
          tens_nx = bcd_tens - 4'd1;
        end else begin
          ones_nx = bcd_ones - 4'd1;
        end
      end
      default: ;
    endcase
  end

  // BCD digit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
    end else begin
      bcd_tens <= tens_nx;
      bcd_ones <= ones_nx;
    end
  end

  // sticky error flags, set wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_ev | (ovf_err & ~clr_err);
      unf_err <= unf_ev | (unf_err & ~clr_err);
    end
  end

  // free-running display refresh counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) refresh <= '0;
    else        refresh <= refresh + 1'b1;
  end

  assign msb   = refresh[REFRESH_BITS-1];
  assign digit = msb ? bcd_tens : bcd_ones;
  assign an    = msb ? 4'b1101 : 4'b1110;

  // segment decode with leading-zero blanking on tens
  always_comb begin
    seg = 7'b1111111;
    if (!(msb && bcd_tens == 4'd0)) begin
      unique case (digit)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_lot_occupancy.sv
// Bench for parking_lot_occupancy: two instances
// (capacity 99 and 5) checked against an arithmetic model.
module tb_parking_lot_occupancy;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc = 1'b0;
  logic dec = 1'b0;
  logic clr = 1'b0;

  logic [6:0] cnt   [2];
  logic [3:0] tens  [2];
  logic [3:0] ones  [2];
  logic       full  [2];
  logic       empty [2];
  logic       ovf   [2];
  logic       unf   [2];
  logic [6:0] seg   [2];
  logic [3:0] an    [2];

  int n_chk = 0;
  int n_fail = 0;

  int cap [2] = '{99, 5};
  int m_cnt [2];
  int m_ovf [2];
  int m_unf [2];
  int m_ref;
  int m_arm;

  always #5 clk = ~clk;

  parking_lot_occupancy #(.CAPACITY(99), .REFRESH_BITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec),
    .clr_err(clr), .count(cnt[0]), .bcd_tens(tens[0]),
    .bcd_ones(ones[0]), .full(full[0]), .empty(empty[0]),
    .ovf_err(ovf[0]), .unf_err(unf[0]), .seg(seg[0]),
    .an(an[0])
  );

  parking_lot_occupancy #(.CAPACITY(5), .REFRESH_BITS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec),
    .clr_err(clr), .count(cnt[1]), .bcd_tens(tens[1]),
    .bcd_ones(ones[1]), .full(full[1]), .empty(empty[1]),
    .ovf_err(ovf[1]), .unf_err(unf[1]), .seg(seg[1]),
    .an(an[1])
  );

  function automatic logic [6:0] code(input int d);
    case (d)
      0: code = 7'b1000000;
      1: code = 7'b1111001;
      2: code = 7'b0100100;
      3: code = 7'b0110000;
      4: code = 7'b0011001;
      5: code = 7'b0010010;
      6: code = 7'b0000010;
      7: code = 7'b1111000;
      8: code = 7'b0000000;
      9: code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int k);
    int t;
    int o;
    t = m_cnt[k] / 10;
    o = m_cnt[k] % 10;
    if (m_ref >= 4) exp_seg = (t == 0) ? 7'h7F : code(t);
    else            exp_seg = code(o);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // occupancy model in plain integer arithmetic
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_arm <= 0;
      m_ref <= 0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] <= 0;
        m_ovf[k] <= 0;
        m_unf[k] <= 0;
      end
    end else begin
      m_ref <= (m_ref + 1) % 8;
      m_arm <= 1;
      if (m_arm != 0) begin
        for (int k = 0; k < 2; k++) begin
          int oe;
          int ue;
          oe = (inc && !dec && m_cnt[k] == cap[k]) ? 1 : 0;
          ue = (dec && !inc && m_cnt[k] == 0) ? 1 : 0;
          if (inc && !dec && m_cnt[k] < cap[k])
            m_cnt[k] <= m_cnt[k] + 1;
          else if (dec && !inc && m_cnt[k] > 0)
            m_cnt[k] <= m_cnt[k] - 1;
          m_ovf[k] <= (oe != 0 || (m_ovf[k] != 0 && !clr)) ? 1 : 0;
          m_unf[k] <= (ue != 0 || (m_unf[k] != 0 && !clr)) ? 1 : 0;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("count%0d", k), cnt[k], m_cnt[k]);
      chk($sformatf("tens%0d", k), tens[k], m_cnt[k] / 10);
      chk($sformatf("ones%0d", k), ones[k], m_cnt[k] % 10);
      chk($sformatf("full%0d", k), full[k],
          (m_cnt[k] == cap[k]) ? 1 : 0);
      chk($sformatf("empty%0d", k), empty[k],
          (m_cnt[k] == 0) ? 1 : 0);
      chk($sformatf("ovf%0d", k), ovf[k], m_ovf[k]);
      chk($sformatf("unf%0d", k), unf[k], m_unf[k]);
      chk($sformatf("seg%0d", k), seg[k], exp_seg(k));
      chk($sformatf("an%0d", k), an[k],
          (m_ref >= 4) ? 4'b1101 : 4'b1110);
    end
  end

  task automatic pulse(input logic i, input logic d,
                       input logic c);
    @(negedge clk);
    inc = i;
    dec = d;
    clr = c;
    @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    clr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_count", cnt[0], 0);
    chk("rst_empty", empty[0], 1);
    chk("rst_an", an[0], 4'b1110);
    chk("rst_seg", seg[0], 7'b1000000);
    do_reset();

    for (int i = 0; i < 12; i++) pulse(1, 0, 0);
    chk("t1_count", cnt[0], 12);
    chk("t1_tens", tens[0], 1);
    chk("t1_ones", ones[0], 2);
    chk("t1_empty", empty[0], 0);
    chk("t1_full", full[0], 0);

    for (int i = 0; i < 3; i++) pulse(0, 1, 0);
    chk("t2_count", cnt[0], 9);
    chk("t2_tens", tens[0], 0);
    chk("t2_ones", ones[0], 9);
    for (int i = 0; i < 8 && m_ref < 4; i++) @(negedge clk);
    chk("t2_blank_seg", seg[0], 7'b1111111);
    chk("t2_blank_an", an[0], 4'b1101);

    do_reset();
    for (int i = 0; i < 6; i++) pulse(1, 0, 0);
    chk("t3_count", cnt[1], 5);
    chk("t3_full", full[1], 1);
    chk("t3_ovf", ovf[1], 1);
    pulse(1, 1, 0);
    chk("t5_full_both", cnt[1], 5);
    chk("t5_ovf_kept", ovf[1], 1);
    pulse(0, 0, 1);
    chk("t3_clr_ovf", ovf[1], 0);
    chk("t3_clr_count", cnt[1], 5);

    do_reset();
    pulse(0, 1, 0);
    chk("t4_count", cnt[0], 0);
    chk("t4_unf", unf[0], 1);
    pulse(0, 1, 1);
    chk("t4_unf_setwins", unf[0], 1);
    pulse(0, 0, 1);
    chk("t4_unf_clr", unf[0], 0);
    pulse(1, 1, 0);
    chk("t5_empty_both", cnt[0], 0);
    chk("t5_unf_quiet", unf[0], 0);

    do_reset();
    @(negedge clk);
    inc = 1'b1;
    repeat (37) @(negedge clk);
    inc = 1'b0;
    chk("t6_count37", cnt[0], 37);
    chk("t6_tens", tens[0], 3);
    chk("t6_ones", ones[0], 7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", cnt[0], 0);
    chk("t6_async_ovf", ovf[1], 0);
    chk("t6_async_an", an[0], 4'b1110);
    chk("t6_async_seg", seg[0], 7'b1000000);
    @(negedge clk);
    inc = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_release_ignored", cnt[0], 0);
    @(negedge clk);
    inc = 1'b0;
    chk("t6_first_accept", cnt[0], 1);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
